// File: rtl/serial_pattern_tx_fsm_pkg.sv
// Shared types and width helpers for the serial pattern transmitter.
package serial_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } tx_state_t;

    // Width of a field holding a pattern length 0..maxLen.
    function automatic int lenWidth(input int maxLen);
        return $clog2(maxLen + 1);
    endfunction

    function automatic int bitCntWidth(input int maxLen);
        return (maxLen < 2) ? 1 : $clog2(maxLen);
    endfunction

    function automatic int gapCntWidth(input int gap);
        return (gap < 1) ? 1 : $clog2(gap + 1);
    endfunction

endpackage

// File: rtl/serial_pattern_tx_fsm_if.sv
// Control/status and serial-line bundle between a pattern source controller and the transmitter.
interface serial_pattern_tx_fsm_if #(
    parameter int MAX_LEN = 8,
    parameter int REP_W   = 4
);
    logic                                       start_i;
    logic                                       abort_i;
    logic [MAX_LEN-1:0]                         pattern_i;
    logic [serial_tx_pkg::lenWidth(MAX_LEN)-1:0] len_i;
    logic [REP_W-1:0]                           reps_i;
    logic                                       a_o;
    logic                                       aValid_o;
    logic                                       busy_o;
    logic                                       done_o;

    modport master (
        output start_i, abort_i, pattern_i, len_i, reps_i,
        input  a_o, aValid_o, busy_o, done_o
    );

    modport slave (
        input  start_i, abort_i, pattern_i, len_i, reps_i,
        output a_o, aValid_o, busy_o, done_o
    );

endinterface

// File: rtl/serial_pattern_tx_fsm_down_counter.sv
// Loadable down-counter with a zero flag; decrement saturates at zero.
module tx_down_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] loadVal_i,
    input  logic         dec_i,
    output logic         zero_o
);
    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = loadVal_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/serial_pattern_tx_fsm.sv
// Serial pattern transmitter: sends a latched pattern MSB first, optionally repeated
// with an idle gap between repetitions, under a start/busy/done handshake.
module serial_pattern_tx_fsm #(
    parameter int MAX_LEN = 8,
    parameter int REP_W   = 4,
    parameter int GAP     = 0
) (
    input logic                    clk,
    input logic                    rst_n,
    serial_pattern_tx_fsm_if.slave bus
);
    import serial_tx_pkg::*;

    localparam int LEN_W = lenWidth(MAX_LEN);
    localparam int BIT_W = bitCntWidth(MAX_LEN);

    tx_state_t          state_q, state_d;
    logic [MAX_LEN-1:0] patternL_q, patternL_d;
    logic [LEN_W-1:0]   lenL_q, lenL_d;
    logic [BIT_W-1:0]   bitCnt_q, bitCnt_d;

    logic             repLoad, repDec, repZero;
    logic             gapLoad, gapDec, gapZero;
    logic             lenOk, lastBit, aBit;
    logic [LEN_W-1:0] bitIdx;

    assign lenOk   = (bus.len_i != '0) && (int'(bus.len_i) <= MAX_LEN);
    assign lastBit = (LEN_W'(bitCnt_q) == (lenL_q - LEN_W'(1)));
    assign bitIdx  = lenL_q - LEN_W'(1) - LEN_W'(bitCnt_q);

    // Mux-select the current pattern bit without an out-of-range index.
    always_comb begin
        aBit = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (LEN_W'(i) == bitIdx) begin
                aBit = patternL_q[i];
            end
        end
    end

    tx_down_counter #(.W(REP_W)) uRepCnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (repLoad),
        .loadVal_i (bus.reps_i),
        .dec_i     (repDec),
        .zero_o    (repZero)
    );

    generate
        if (GAP > 0) begin : gGapCnt
            localparam int GAP_W = gapCntWidth(GAP);
            tx_down_counter #(.W(GAP_W)) uGapCnt (
                .clk       (clk),
                .rst_n     (rst_n),
                .load_i    (gapLoad),
                .loadVal_i (GAP_W'(GAP - 1)),
                .dec_i     (gapDec),
                .zero_o    (gapZero)
            );
        end else begin : gNoGap
            logic unusedGapCtl;
            assign unusedGapCtl = gapLoad | gapDec;
            assign gapZero      = 1'b1;
        end
    endgenerate

    // Abort outranks every other transition; start is only honoured from IDLE.
    always_comb begin
        state_d    = state_q;
        patternL_d = patternL_q;
        lenL_d     = lenL_q;
        bitCnt_d   = bitCnt_q;
        repLoad    = 1'b0;
        repDec     = 1'b0;
        gapLoad    = 1'b0;
        gapDec     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start_i && !bus.abort_i && lenOk) begin
                    patternL_d = bus.pattern_i;
                    lenL_d     = bus.len_i;
                    bitCnt_d   = '0;
                    repLoad    = 1'b1;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (bus.abort_i) begin
                    state_d = IDLE;
                end else if (lastBit) begin
                    bitCnt_d = '0;
                    if (!repZero) begin
                        repDec = 1'b1;
                        if (GAP > 0) begin
                            gapLoad = 1'b1;
                            state_d = serial_tx_pkg::GAP;
                        end
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    bitCnt_d = bitCnt_q + BIT_W'(1);
                end
            end
            serial_tx_pkg::GAP: begin
                if (bus.abort_i) begin
                    state_d = IDLE;
                end else if (gapZero) begin
                    state_d = SEND;
                end else begin
                    gapDec = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            patternL_q <= '0;
            lenL_q     <= '0;
            bitCnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            patternL_q <= patternL_d;
            lenL_q     <= lenL_d;
            bitCnt_q   <= bitCnt_d;
        end
    end

    assign bus.a_o      = (state_q == SEND) && aBit;
    assign bus.aValid_o = (state_q == SEND);
    assign bus.busy_o   = (state_q != IDLE);
    assign bus.done_o   = (state_q == DONE);

endmodule

// File: tb/tb_serial_pattern_tx_fsm.sv
// Bench for serial_pattern_tx_fsm: a back-to-back instance (GAP=0) and a gapped one (GAP=2)
// share all stimulus and are each compared cycle by cycle against an arithmetic model.
module tb_serial_pattern_tx_fsm;
    localparam int MAX_LEN = 8;
    localparam int REP_W   = 4;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);
    localparam int GAP_B   = 2;

    // Observation word: {a, a_valid, busy, done}
    typedef logic [3:0] obs_t;

    typedef struct packed {
        logic [7:0] pattern;
        int         len;
        int         reps;
        int         expDoneA;
        int         expDoneB;
        int         expDet;
    } vector_t;

    logic    clk   = 1'b0;
    logic    rst_n = 1'b0;
    int      checks   = 0;
    int      failures = 0;
    vector_t vecs[6];

    always #5 clk = ~clk;

    serial_pattern_tx_fsm_if #(.MAX_LEN(MAX_LEN), .REP_W(REP_W)) busA ();
    serial_pattern_tx_fsm_if #(.MAX_LEN(MAX_LEN), .REP_W(REP_W)) busB ();

    serial_pattern_tx_fsm #(.MAX_LEN(MAX_LEN), .REP_W(REP_W), .GAP(0)) dutA (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busA.slave)
    );

    serial_pattern_tx_fsm #(.MAX_LEN(MAX_LEN), .REP_W(REP_W), .GAP(GAP_B)) dutB (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busB.slave)
    );

    function automatic obs_t obsA();
        return {busA.a_o, busA.aValid_o, busA.busy_o, busA.done_o};
    endfunction

    function automatic obs_t obsB();
        return {busB.a_o, busB.aValid_o, busB.busy_o, busB.done_o};
    endfunction

    // Expected outputs c cycles after the start edge, straight from the timing rules.
    function automatic obs_t modelAt(input logic [7:0] pat, input int len, input int reps,
                                     input int gap, input int c);
        int t, total, off;
        if (len < 1 || len > MAX_LEN) return 4'b0000;
        t     = c - 1;
        total = len * (reps + 1) + gap * reps;
        if (t < total) begin
            off = t % (len + gap);
            if (off < len) return {pat[len - 1 - off], 3'b110};
            return 4'b0010;
        end
        if (t == total) return 4'b0011;
        return 4'b0000;
    endfunction

    task automatic driveInputs(input logic s, input logic ab, input logic [7:0] p,
                               input logic [LEN_W-1:0] l, input logic [REP_W-1:0] r);
        busA.start_i = s;  busA.abort_i = ab; busA.pattern_i = p; busA.len_i = l; busA.reps_i = r;
        busB.start_i = s;  busB.abort_i = ab; busB.pattern_i = p; busB.len_i = l; busB.reps_i = r;
    endtask

    task automatic checkOutput(input string name, input int cyc, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s cycle %0d: a/v/busy/done got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic checkValue(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic checkIdle(input string name, input int cyc);
        checkOutput({name, " dutA"}, cyc, obsA(), 4'b0000);
        checkOutput({name, " dutB"}, cyc, obsB(), 4'b0000);
    endtask

    // Launches one transmission from a negedge and checks both instances until well past done.
    task automatic applyStimulus(input string name, input logic [7:0] pat, input int len,
                                 input int reps, input bit disturb, input int expDoneA,
                                 input int expDoneB, input int expDet);
        bit         valid;
        int         horizon;
        int         doneA = -1;
        int         doneB = -1;
        int         detA  = 0;
        int         detB  = 0;
        int         nA    = 0;
        int         nB    = 0;
        logic [5:0] shA   = '0;
        logic [5:0] shB   = '0;
        obs_t       oA, oB;
        valid   = (len >= 1) && (len <= MAX_LEN);
        horizon = valid ? (len * (reps + 1) + GAP_B * reps + 4) : 6;
        driveInputs(1'b1, 1'b0, pat, LEN_W'(len), REP_W'(reps));
        for (int c = 1; c <= horizon; c++) begin
            @(negedge clk);
            oA = obsA();
            oB = obsB();
            checkOutput({name, " dutA"}, c, oA, modelAt(pat, len, reps, 0, c));
            checkOutput({name, " dutB"}, c, oB, modelAt(pat, len, reps, GAP_B, c));
            if (oA[0] && doneA < 0) doneA = c;
            if (oB[0] && doneB < 0) doneB = c;
            if (oA[2]) begin
                shA = {shA[4:0], oA[3]};
                nA++;
                if (nA >= 6 && shA == 6'b110011) detA++;
            end
            if (oB[2]) begin
                shB = {shB[4:0], oB[3]};
                nB++;
                if (nB >= 6 && shB == 6'b110011) detB++;
            end
            if (c == 1 || c == 3) begin
                driveInputs(1'b0, 1'b0, 8'($urandom), LEN_W'($urandom), REP_W'($urandom));
            end else if (c == 2 && disturb && valid) begin
                driveInputs(1'b1, 1'b0, ~pat, LEN_W'(3), REP_W'(5));
            end
        end
        if (expDoneA >= 0) checkValue({name, " done latency dutA"}, doneA, expDoneA);
        if (expDoneB >= 0) checkValue({name, " done latency dutB"}, doneB, expDoneB);
        if (expDet >= 0) begin
            checkValue({name, " 110011 detections dutA"}, detA, expDet);
            checkValue({name, " 110011 detections dutB"}, detB, expDet);
        end
    endtask

    initial begin
        int len, reps;

        vecs[0] = '{8'b0011_0011, 6, 0,  7,  7, 1};
        vecs[1] = '{8'b0000_1010, 4, 2, 13, 17, 0};
        vecs[2] = '{8'b0000_0101, 3, 1,  7,  9, 0};
        vecs[3] = '{8'b1010_0101, 8, 0,  9,  9, 0};
        vecs[4] = '{8'b0000_0001, 1, 3,  5, 11, 0};
        vecs[5] = '{8'b0000_0001, 2, 15, 33, 63, 0};

        driveInputs(1'b0, 1'b0, 8'h00, '0, '0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            checkIdle("in reset", c);
        end
        rst_n = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            checkIdle("after reset", c);
        end

        for (int i = 0; i < 6; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i].pattern, vecs[i].len, vecs[i].reps,
                          (i % 2) == 1, vecs[i].expDoneA, vecs[i].expDoneB, vecs[i].expDet);
        end

        // Abort on the third bit of an 8-bit send: idle next cycle and no done afterwards.
        driveInputs(1'b1, 1'b0, 8'hB4, LEN_W'(8), REP_W'(0));
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            checkOutput("abort lead-in dutA", c, obsA(), modelAt(8'hB4, 8, 0, 0, c));
            checkOutput("abort lead-in dutB", c, obsB(), modelAt(8'hB4, 8, 0, GAP_B, c));
            if (c == 1) driveInputs(1'b0, 1'b0, 8'hB4, LEN_W'(8), REP_W'(0));
        end
        driveInputs(1'b0, 1'b1, 8'hB4, LEN_W'(8), REP_W'(0));
        @(negedge clk);
        checkIdle("after abort", 4);
        driveInputs(1'b0, 1'b0, 8'hB4, LEN_W'(8), REP_W'(0));
        for (int c = 5; c <= 14; c++) begin
            @(negedge clk);
            checkIdle("post abort", c);
        end

        // start together with abort in IDLE, and start with len=0: both ignored.
        driveInputs(1'b1, 1'b1, 8'hFF, LEN_W'(8), REP_W'(0));
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            checkIdle("start+abort idle", c);
        end
        driveInputs(1'b1, 1'b0, 8'hFF, LEN_W'(0), REP_W'(0));
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            checkIdle("start len0", c);
        end
        driveInputs(1'b0, 1'b0, 8'h00, '0, '0);

        // Asynchronous reset between edges in mid-SEND clears outputs at once.
        driveInputs(1'b1, 1'b0, 8'hFF, LEN_W'(8), REP_W'(3));
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            checkOutput("pre async reset dutA", c, obsA(), modelAt(8'hFF, 8, 3, 0, c));
            checkOutput("pre async reset dutB", c, obsB(), modelAt(8'hFF, 8, 3, GAP_B, c));
            if (c == 1) driveInputs(1'b0, 1'b0, 8'hFF, LEN_W'(8), REP_W'(3));
        end
        #2 rst_n = 1'b0;
        #1 checkIdle("async reset immediate", 0);
        @(negedge clk);
        checkIdle("async reset held", 1);
        rst_n = 1'b1;
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk);
            checkIdle("after async reset", c);
        end

        for (int k = 0; k < 24; k++) begin
            if ($urandom_range(0, 5) == 0) begin
                len = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(9, 15));
            end else begin
                len = int'($urandom_range(1, MAX_LEN));
            end
            reps = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 3));
            applyStimulus($sformatf("rand%0d", k), 8'($urandom), len, reps,
                          $urandom_range(0, 1) == 1, -1, -1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
